// File: rtl/dmem_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bridge
// Data-memory side of the core. Takes the M-stage memory access and turns it
// into single word-wide req/ack bus transactions. An isolated store is posted
// and does not stall the pipeline. Loads stall until the bus returns data.
// Misaligned accesses and bus timeouts raise a sticky error flag.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   memenM, memwriteM    M-stage access valid / store(1) or load(0)
//   aluoutM, writedataM  byte address and store data of the access
//   readdataM            registered load data
//   stallM               pipeline freeze, combinational from state and inputs
//   bus_req/we/addr/wdata  registered bus request (addr is word aligned)
//   bus_ack, bus_rdata   bus completion and read data
//   bus_err              sticky error flag, cleared only by rst
// -----------------------------------------------------------------------------
module dmem_bridge #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter logic [31:0] ERR_RDATA   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memenM,
    input  logic        memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WR_BUSY = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] RD_DONE = 2'd3;

    // Timeout fires in the cycle where the counter already holds TIMEOUT_CYC-1,
    // so bus_req stays high for exactly TIMEOUT_CYC cycles.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 32'd1);

    logic [1:0]  state_q,     state_d;
    logic        bus_req_q,   bus_req_d;
    logic        bus_we_q,    bus_we_d;
    logic [31:0] bus_addr_q,  bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q,     rdata_d;
    logic        err_q,       err_d;
    logic [7:0]  to_cnt_q,    to_cnt_d;

    logic        misaligned_s;
    logic        ack_s;
    logic        timeout_s;
    logic        stall_s;

    assign misaligned_s = memenM & (aluoutM[1:0] != 2'b00);
    // An ack with no request outstanding is ignored.
    assign ack_s        = bus_req_q & bus_ack;
    // Ack wins over timeout when both land in the same cycle.
    assign timeout_s    = bus_req_q & ~bus_ack & (to_cnt_q == TO_LAST);

    // Timeout counter: runs while a request waits, clears once it drops.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (!bus_req_q) begin
            to_cnt_d = 8'd0;
        end else if (!bus_ack) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end else begin
            to_cnt_d = to_cnt_q;
        end
    end

    // Next-state, bus request and stall decode.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        stall_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (misaligned_s) begin
                    err_d = 1'b1;
                    if (!memwriteM) begin
                        rdata_d = ERR_RDATA;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (memenM && memwriteM) begin
                    // Posted store: the pipeline moves on while the bus drains it.
                    bus_addr_d  = {aluoutM[31:2], 2'b00};
                    bus_wdata_d = writedataM;
                    bus_we_d    = 1'b1;
                    bus_req_d   = 1'b1;
                    state_d     = WR_BUSY;
                end else if (memenM) begin
                    stall_s    = 1'b1;
                    bus_addr_d = {aluoutM[31:2], 2'b00};
                    bus_we_d   = 1'b0;
                    bus_req_d  = 1'b1;
                    state_d    = RD_WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_BUSY: begin
                // Any new access waits for the drain; this keeps store->load
                // ordering on the bus without forwarding.
                stall_s = memenM;
                if (ack_s) begin
                    bus_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (timeout_s) begin
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = WR_BUSY;
                end
            end
            RD_WAIT: begin
                stall_s = 1'b1;
                if (ack_s) begin
                    rdata_d   = bus_rdata;
                    bus_req_d = 1'b0;
                    state_d   = RD_DONE;
                end else if (timeout_s) begin
                    rdata_d   = ERR_RDATA;
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = RD_DONE;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            RD_DONE: begin
                // memenM still belongs to the completing load; issue nothing.
                state_d = IDLE;
            end
            default: begin
                bus_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_wdata_q <= 32'h0000_0000;
            rdata_q     <= 32'h0000_0000;
            err_q       <= 1'b0;
            to_cnt_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign readdataM = rdata_q;
    assign stallM    = stall_s;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_err   = err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_bridge
// Self-checking bench for dmem_bridge: a vector table of single accesses, a
// store-then-load ordering sequence and a read timeout. Expected bus
// transactions and load data are queued when an access is driven and compared
// once the bus responder / pipeline sees them complete.
// -----------------------------------------------------------------------------
module tb_dmem_bridge;

    localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic        memenM;
    logic        memwriteM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic        stallM;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    dmem_bridge #(.TIMEOUT_CYC(8), .ERR_RDATA(ERR_VAL)) dut (
        .clk(clk), .rst(rst),
        .memenM(memenM), .memwriteM(memwriteM),
        .aluoutM(aluoutM), .writedataM(writedataM),
        .readdataM(readdataM), .stallM(stallM),
        .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        int          exp_stalls;
        int          exp_req;
        logic [31:0] exp_rd;
        logic [31:0] exp_hold;
        logic        exp_err;
    } vec_t;

    int          n_chk;
    int          n_err;
    txn_t        exp_q[$];
    logic [31:0] rd_q[$];
    txn_t        obs_a[64];
    int          obs_n;
    int          obs_rd;
    int          req_hi_cnt;
    int          wait_cnt;
    int          cur_waits;
    logic        no_ack;
    logic        ack_resp;
    logic        tog_en;
    logic        tog_val;
    logic [31:0] mem [logic [31:0]];
    vec_t        vecs[10];

    assign bus_ack = tog_en ? tog_val : ack_resp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Bus responder / RAM model: acks after cur_waits wait cycles, logs txns.
    initial begin
        ack_resp   = 1'b0;
        wait_cnt   = 0;
        req_hi_cnt = 0;
        obs_n      = 0;
        bus_rdata  = 32'h0000_0000;
        mem[32'h0000_0020] = 32'h1234_5678;
        mem[32'h0000_0040] = 32'h0000_0077;
        forever begin
            @(negedge clk);
            if (bus_req === 1'b1) begin
                req_hi_cnt++;
                if (!no_ack && wait_cnt == cur_waits) begin
                    ack_resp = 1'b1;
                    wait_cnt = 0;
                    if (bus_we) begin
                        mem[bus_addr] = bus_wdata;
                    end else begin
                        bus_rdata = mem.exists(bus_addr) ? mem[bus_addr] : 32'h0000_0000;
                    end
                    if (obs_n < 64) begin
                        obs_a[obs_n] = '{bus_we, bus_addr, bus_wdata};
                        obs_n++;
                    end
                end else begin
                    ack_resp = 1'b0;
                    wait_cnt++;
                end
            end else begin
                ack_resp = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Drive one access into M and hold it until stallM releases it.
    task automatic run_access(input logic we, input logic [31:0] addr,
                              input logic [31:0] wd, output int stalls);
        memenM     = 1'b1;
        memwriteM  = we;
        aluoutM    = addr;
        writedataM = wd;
        stalls     = 0;
        #1;
        while (stallM === 1'b1 && stalls < 100) begin
            stalls++;
            @(posedge clk);
            #3;
        end
        if (stalls >= 100) begin
            n_chk++;
            n_err++;
            $display("FAIL stall_bound: got stuck stall expected release");
        end
        if (!we && addr[1:0] == 2'b00) begin
            if (rd_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL load_data: got load with no expectation expected none");
            end else begin
                chk("load_data", readdataM, rd_q.pop_front());
            end
        end
        @(posedge clk);
        #2;
        memenM    = 1'b0;
        memwriteM = 1'b0;
    endtask

    // Compare logged bus transactions against the expected queue.
    task automatic check_bus();
        txn_t e;
        while (obs_rd < obs_n) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL bus_unexpected: got addr %h expected no txn", obs_a[obs_rd].addr);
            end else begin
                e = exp_q.pop_front();
                chk("bus_we", 32'(obs_a[obs_rd].we), 32'(e.we));
                chk("bus_addr", obs_a[obs_rd].addr, e.addr);
                if (e.we) begin
                    chk("bus_wdata", obs_a[obs_rd].wdata, e.wdata);
                end else begin
                    chk("bus_rd_dir", 32'(obs_a[obs_rd].we), 32'd0);
                end
            end
            obs_rd++;
        end
    endtask

    // Let any posted write drain, then settle the bus scoreboard.
    task automatic drain();
        int n;
        n = 0;
        while (bus_req === 1'b1 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 200) begin
            n_chk++;
            n_err++;
            $display("FAIL drain_bound: got bus_req stuck expected drop");
        end
        check_bus();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   stalls;
        int   base;
        vec_t v;

        n_chk      = 0;
        n_err      = 0;
        obs_rd     = 0;
        rst        = 1'b1;
        memenM     = 1'b0;
        memwriteM  = 1'b0;
        aluoutM    = 32'h0000_0000;
        writedataM = 32'h0000_0000;
        cur_waits  = 0;
        no_ack     = 1'b0;
        tog_en     = 1'b1;
        tog_val    = 1'b1;

        //          we    addr          wdata         w  stl req exp_rd        exp_hold      err
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_0001, 0, 0, 1, 32'h0,        32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         1, 3, 2, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0020, 32'h0,         3, 5, 4, 32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_0024, 32'hCAFE_0002, 5, 0, 6, 32'h0,        32'h1234_5678, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_0024, 32'h0,         0, 2, 1, 32'hCAFE_0002, 32'hCAFE_0002, 1'b0};
        vecs[5] = '{1'b0, 32'h0000_0022, 32'h0,         0, 0, 0, 32'h0,        ERR_VAL,       1'b1};
        vecs[6] = '{1'b1, 32'h0000_0013, 32'hFFFF_FFFF, 0, 0, 0, 32'h0,        ERR_VAL,       1'b1};
        vecs[7] = '{1'b0, 32'h0000_0010, 32'h0,         2, 4, 3, 32'hA5A5_0001, 32'hA5A5_0001, 1'b1};
        vecs[8] = '{1'b1, 32'hFFFF_FFFC, 32'h5A5A_5A5A, 6, 0, 7, 32'h0,        32'hA5A5_0001, 1'b1};
        vecs[9] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         7, 9, 8, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b1};

        // Reset for two edges while bus_ack toggles.
        @(posedge clk);
        #2 tog_val = 1'b0;
        @(posedge clk);
        #2 tog_val = 1'b1;
        #1;
        chk("rst_readdata", readdataM, 32'h0000_0000);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'h0000_0000);
        chk("rst_bus_wdata", bus_wdata, 32'h0000_0000);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_stall", 32'(stallM), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #2 tog_val = 1'b0;
        @(posedge clk);
        #3;
        chk("idle_ack_ignored_req", 32'(bus_req), 32'd0);
        chk("idle_stall", 32'(stallM), 32'd0);
        tog_en = 1'b0;
        @(posedge clk);
        #2;

        for (int i = 0; i < 10; i++) begin
            v         = vecs[i];
            cur_waits = v.waits;
            base      = req_hi_cnt;
            if (v.addr[1:0] == 2'b00) begin
                exp_q.push_back('{v.we, v.addr, v.wdata});
                if (!v.we) begin
                    rd_q.push_back(v.exp_rd);
                end
            end
            run_access(v.we, v.addr, v.wdata, stalls);
            drain();
            chk($sformatf("vec%0d_stalls", i), 32'(stalls), 32'(v.exp_stalls));
            chk($sformatf("vec%0d_req_cycles", i), 32'(req_hi_cnt - base), 32'(v.exp_req));
            chk($sformatf("vec%0d_readdata", i), readdataM, v.exp_hold);
            chk($sformatf("vec%0d_bus_err", i), 32'(bus_err), 32'(v.exp_err));
        end

        // Store then immediate load to the same word: write must reach the bus first.
        cur_waits = 2;
        base      = req_hi_cnt;
        exp_q.push_back('{1'b1, 32'h0000_0040, 32'h0000_0001});
        exp_q.push_back('{1'b0, 32'h0000_0040, 32'h0000_0000});
        rd_q.push_back(32'h0000_0001);
        run_access(1'b1, 32'h0000_0040, 32'h0000_0001, stalls);
        chk("stld_store_stalls", 32'(stalls), 32'd0);
        run_access(1'b0, 32'h0000_0040, 32'h0000_0000, stalls);
        chk("stld_load_stalls", 32'(stalls), 32'd7);
        drain();
        chk("stld_req_cycles", 32'(req_hi_cnt - base), 32'd6);
        chk("stld_readdata", readdataM, 32'h0000_0001);

        // Fresh reset, then a load that never gets acked.
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        chk("rst2_bus_err", 32'(bus_err), 32'd0);
        chk("rst2_readdata", readdataM, 32'h0000_0000);
        no_ack = 1'b1;
        base   = req_hi_cnt;
        rd_q.push_back(ERR_VAL);
        run_access(1'b0, 32'h0000_0080, 32'h0000_0000, stalls);
        drain();
        chk("to_stalls", 32'(stalls), 32'd9);
        chk("to_req_cycles", 32'(req_hi_cnt - base), 32'd8);
        chk("to_bus_req_low", 32'(bus_req), 32'd0);
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_readdata", readdataM, ERR_VAL);
        no_ack = 1'b0;

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("rd_q_empty", 32'(rd_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
